k10_uart_tx_feeder: RTL and testbench

K10_UART_TX_FEEDER -- requirements
Module: k10_uart_tx_feeder

---
 rtl/k10_uart_pkg.sv | 27 ++
 rtl/k10_sync_fifo.sv | 69 ++++++
 rtl/k10_uart_tx_feeder.sv | 161 ++++++++++++++++
 tb/tb_k10_uart_tx_feeder.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/k10_uart_pkg.sv
// Shared constants for the UART TX feeder: downstream register map,
// STATUS bit positions, AXI response codes and the feeder FSM state type.
package k10_uart_pkg;

  localparam logic [31:0] UART_TXDATA_OFS   = 32'h0000_0000;
  localparam logic [31:0] UART_STATUS_OFS   = 32'h0000_0004;
  localparam logic [31:0] UART_IRQ_EN_OFS   = 32'h0000_0008;
  localparam logic [31:0] UART_BAUD_OFS     = 32'h0000_000C;
  localparam logic [31:0] UART_IRQ_PEND_OFS = 32'h0000_0010;

  localparam int STATUS_TX_READY_BIT = 0;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR      = 3'd3,
    ST_WR_RESP = 3'd4
  } feeder_state_e;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/k10_sync_fifo.sv
// Single-clock FIFO with registered occupancy; push is ignored when full
// and pop is ignored when empty. DEPTH must be a power of two.
module k10_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q,  level_d;
  logic             do_push;
  logic             do_pop;

  assign o_full  = (level_q == LW'(DEPTH));
  assign o_empty = (level_q == '0);
  assign o_level = level_q;
  assign o_data  = mem_q[rd_ptr_q];

  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop  && !o_empty;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // Power-of-two depth: pointer overflow is the modulo wrap.
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and level define which entries are meaningful.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

// File: rtl/k10_uart_tx_feeder.sv
// Buffers producer bytes and forwards each one to an AXI4-Lite UART: poll
// STATUS until TX_READY, write TXDATA, wait for the write response, then pop.
module k10_uart_tx_feeder
  import k10_uart_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] UART_BASE  = 32'h1000_0000
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [7:0]                    i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_busy,
  output logic                          o_err,

  output logic [31:0]                   m_axi_awaddr,
  output logic [2:0]                    m_axi_awprot,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,

  output logic [31:0]                   m_axi_wdata,
  output logic [3:0]                    m_axi_wstrb,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,

  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,

  output logic [31:0]                   m_axi_araddr,
  output logic [2:0]                    m_axi_arprot,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,

  input  logic [31:0]                   m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  feeder_state_e state_q, state_d;
  logic          aw_done_q, aw_done_d;
  logic          w_done_q,  w_done_d;
  logic          err_q,     err_d;
  logic          rdy_en_q,  rdy_en_d;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_head;
  logic          aw_fire;
  logic          w_fire;
  logic          rdata_unused;

  k10_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (fifo_push),
    .i_data  (i_data),
    .i_pop   (fifo_pop),
    .o_data  (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (o_level)
  );

  // rdy_en_q keeps o_ready low through reset while staying purely registered.
  assign o_ready   = rdy_en_q && !fifo_full;
  assign fifo_push = i_valid && o_ready;
  assign o_busy    = (state_q != ST_IDLE) || !fifo_empty;
  assign o_err     = err_q;
  assign rdy_en_d  = 1'b1;

  assign m_axi_araddr  = UART_BASE + UART_STATUS_OFS;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = (state_q == ST_RD_ADDR);
  assign m_axi_rready  = (state_q == ST_RD_DATA);

  assign m_axi_awaddr  = UART_BASE + UART_TXDATA_OFS;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wdata   = {24'd0, fifo_head};
  assign m_axi_wstrb   = 4'b0001;
  assign m_axi_awvalid = (state_q == ST_WR) && !aw_done_q;
  assign m_axi_wvalid  = (state_q == ST_WR) && !w_done_q;
  assign m_axi_bready  = (state_q == ST_WR_RESP);

  assign aw_fire = m_axi_awvalid && m_axi_awready;
  assign w_fire  = m_axi_wvalid  && m_axi_wready;

  // Only TX_READY of STATUS matters to the feeder.
  assign rdata_unused = ^m_axi_rdata[31:1];

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    err_d     = err_q;
    fifo_pop  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_RD_ADDR;
      end

      ST_RD_ADDR: begin
        if (m_axi_arready) state_d = ST_RD_DATA;
      end

      ST_RD_DATA: begin
        if (m_axi_rvalid) begin
          if (resp_is_err(m_axi_rresp)) err_d = 1'b1;
          state_d = m_axi_rdata[STATUS_TX_READY_BIT] ? ST_WR : ST_RD_ADDR;
        end
      end

      ST_WR: begin
        if (aw_fire) aw_done_d = 1'b1;
        if (w_fire)  w_done_d  = 1'b1;
        // The two channels complete independently; leave once both have.
        if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = ST_WR_RESP;
        end
      end

      ST_WR_RESP: begin
        if (m_axi_bvalid) begin
          if (resp_is_err(m_axi_bresp)) err_d = 1'b1;
          fifo_pop = 1'b1;
          state_d  = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
      rdy_en_q  <= rdy_en_d;
    end
  end

endmodule

// File: tb/tb_k10_uart_tx_feeder.sv
// Directed bench for k10_uart_tx_feeder against a behavioural AXI4-Lite
// UART slave with configurable STATUS polling, stalls, delays and bresp.
module tb_k10_uart_tx_feeder;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [7:0]    i_data;
  logic          i_valid;
  logic          o_ready;
  logic [LW-1:0] o_level;
  logic          o_busy;
  logic          o_err;

  logic [31:0] m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [31:0] m_axi_araddr;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  always #5 i_clk = ~i_clk;

  k10_uart_tx_feeder #(
    .FIFO_DEPTH (DEPTH),
    .UART_BASE  (32'h1000_0000)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_data        (i_data),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .o_level       (o_level),
    .o_busy        (o_busy),
    .o_err         (o_err),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awprot  (m_axi_awprot),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arprot  (m_axi_arprot),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural slave ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [2:0]  prot;
  } wr_rec_t;

  wr_rec_t     wr_q[$];
  int          n_reads     = 0;
  logic [31:0] last_araddr = '0;
  logic [2:0]  last_arprot = '0;
  int          zeros_left  = 0;
  bit          ar_stall    = 1'b0;
  int          aw_dly      = 0;
  int          w_dly       = 0;
  logic [1:0]  bresp_cfg   = 2'b00;
  int          n_overlap   = 0;
  bit          saw_bready  = 1'b0;

  initial begin
    int          aw_wait = 0;
    int          w_wait  = 0;
    bit          aw_got  = 1'b0;
    bit          w_got   = 1'b0;
    wr_rec_t     rec     = '0;
    bit          rst_s, ar_hs, r_hs, aw_hs, w_hs, b_hs, awv_s, wv_s;
    logic [31:0] araddr_s, awaddr_s, wdata_s;
    logic [2:0]  arprot_s, awprot_s;
    logic [3:0]  wstrb_s;

    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = '0;
    forever begin
      @(posedge i_clk);
      rst_s    = i_rst;
      ar_hs    = m_axi_arvalid && m_axi_arready;
      r_hs     = m_axi_rvalid  && m_axi_rready;
      aw_hs    = m_axi_awvalid && m_axi_awready;
      w_hs     = m_axi_wvalid  && m_axi_wready;
      b_hs     = m_axi_bvalid  && m_axi_bready;
      awv_s    = m_axi_awvalid;
      wv_s     = m_axi_wvalid;
      araddr_s = m_axi_araddr;  arprot_s = m_axi_arprot;
      awaddr_s = m_axi_awaddr;  awprot_s = m_axi_awprot;
      wdata_s  = m_axi_wdata;   wstrb_s  = m_axi_wstrb;
      if ((m_axi_arvalid || m_axi_rready) && (m_axi_awvalid || m_axi_wvalid || m_axi_bready))
        n_overlap++;
      if (m_axi_bready) saw_bready = 1'b1;
      #1;
      if (rst_s) begin
        m_axi_rvalid = 1'b0; m_axi_bvalid = 1'b0;
        aw_got = 1'b0; w_got = 1'b0; aw_wait = 0; w_wait = 0;
      end else begin
        if (r_hs) m_axi_rvalid = 1'b0;
        if (b_hs) m_axi_bvalid = 1'b0;
        if (ar_hs) begin
          n_reads++;
          last_araddr  = araddr_s;
          last_arprot  = arprot_s;
          m_axi_rvalid = 1'b1;
          m_axi_rresp  = 2'b00;
          m_axi_rdata  = (zeros_left > 0) ? 32'h0 : 32'h1;
          if (zeros_left > 0) zeros_left--;
        end
        if (aw_hs) begin aw_got = 1'b1; rec.addr = awaddr_s; rec.prot = awprot_s; end
        if (w_hs)  begin w_got  = 1'b1; rec.data = wdata_s;  rec.strb = wstrb_s;  end
        if (aw_got && w_got) begin
          wr_q.push_back(rec);
          aw_got = 1'b0; w_got = 1'b0;
          m_axi_bvalid = 1'b1;
          m_axi_bresp  = bresp_cfg;
        end
        if (aw_hs) aw_wait = 0; else if (awv_s) aw_wait++;
        if (w_hs)  w_wait  = 0; else if (wv_s)  w_wait++;
      end
      m_axi_arready = m_axi_arvalid && !ar_stall;
      m_axi_awready = m_axi_awvalid && (aw_wait >= aw_dly);
      m_axi_wready  = m_axi_wvalid  && (w_wait  >= w_dly);
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Returns one tick after the accepting edge.
  task automatic push_byte(input logic [7:0] d);
    bit hs = 1'b0;
    i_data  = d;
    i_valid = 1'b1;
    for (int c = 0; c < 500; c++) begin
      hs = o_ready;
      tick();
      if (hs) break;
    end
    i_valid = 1'b0;
    check("push_accept", 32'(hs), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int n);
    int c = 0;
    while ((wr_q.size() < n || o_busy) && c < 3000) begin
      tick();
      c++;
    end
    check(tag, 32'(c < 3000), 32'd1);
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_ready"},   32'(o_ready),       32'd0);
    check({pfx, "_level"},   32'(o_level),       32'd0);
    check({pfx, "_busy"},    32'(o_busy),        32'd0);
    check({pfx, "_err"},     32'(o_err),         32'd0);
    check({pfx, "_arvalid"}, 32'(m_axi_arvalid), 32'd0);
    check({pfx, "_rready"},  32'(m_axi_rready),  32'd0);
    check({pfx, "_awvalid"}, 32'(m_axi_awvalid), 32'd0);
    check({pfx, "_wvalid"},  32'(m_axi_wvalid),  32'd0);
    check({pfx, "_bready"},  32'(m_axi_bready),  32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    wr_rec_t w;
    int      snap_r, snap_w;
    bit      seen, any_ar;

    i_rst = 1'b1; i_valid = 1'b0; i_data = '0;
    repeat (3) tick();
    check_idle_outputs("rst");
    i_rst = 1'b0;
    tick();
    check("ready_after_rst", 32'(o_ready), 32'd1);

    // Single byte through a zero-wait slave, including the AR latency.
    push_byte(8'h41);
    check("arvalid_cyc1", 32'(m_axi_arvalid), 32'd0);
    tick();
    check("arvalid_cyc2", 32'(m_axi_arvalid), 32'd1);
    wait_done("t1_done", 1);
    check("t1_reads",  n_reads,        32'd1);
    check("t1_araddr", last_araddr,    32'h1000_0004);
    check("t1_arprot", 32'(last_arprot), 32'd0);
    check("t1_writes", wr_q.size(),    32'd1);
    w = wr_q[0];
    check("t1_awaddr", w.addr,         32'h1000_0000);
    check("t1_wdata",  w.data,         32'h0000_0041);
    check("t1_wstrb",  32'(w.strb),    32'h1);
    check("t1_awprot", 32'(w.prot),    32'd0);
    check("t1_level",  32'(o_level),   32'd0);
    check("t1_busy",   32'(o_busy),    32'd0);
    check("t1_err",    32'(o_err),     32'd0);

    // STATUS not ready three times, then ready.
    wr_q.delete(); n_reads = 0; zeros_left = 3;
    push_byte(8'h5A);
    wait_done("t2_done", 1);
    check("t2_reads",  n_reads,     32'd4);
    check("t2_writes", wr_q.size(), 32'd1);
    w = wr_q[0];
    check("t2_wdata",  w.data,      32'h0000_005A);

    // Fill while AR is stalled, hold a ninth byte, then drain in order.
    wr_q.delete(); n_reads = 0; ar_stall = 1'b1;
    for (int i = 0; i < 8; i++) push_byte(8'(i));
    check("t3_level_full", 32'(o_level), 32'd8);
    check("t3_ready_full", 32'(o_ready), 32'd0);
    i_data = 8'h08; i_valid = 1'b1;
    repeat (4) tick();
    check("t3_ready_held", 32'(o_ready),       32'd0);
    check("t3_level_held", 32'(o_level),       32'd8);
    check("t3_ar_held",    32'(m_axi_arvalid), 32'd1);
    check("t3_no_write",   wr_q.size(),        32'd0);
    ar_stall = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 500; c++) begin
      seen = o_ready;
      tick();
      if (seen) break;
    end
    i_valid = 1'b0;
    check("t3_ninth_accept", 32'(seen), 32'd1);
    wait_done("t3_done", 9);
    check("t3_writes", wr_q.size(), 32'd9);
    for (int i = 0; i < 9 && i < wr_q.size(); i++) begin
      w = wr_q[i];
      check($sformatf("t3_order%0d", i), w.data, 32'(i));
    end

    // W accepted well after AW.
    wr_q.delete(); saw_bready = 1'b0; aw_dly = 0; w_dly = 3;
    push_byte(8'h33);
    wait_done("t4a_done", 1);
    check("t4a_writes", wr_q.size(),     32'd1);
    w = wr_q[0];
    check("t4a_wdata",  w.data,          32'h33);
    check("t4a_bready", 32'(saw_bready), 32'd1);

    // AW accepted well after W.
    wr_q.delete(); saw_bready = 1'b0; aw_dly = 3; w_dly = 0;
    push_byte(8'h34);
    wait_done("t4b_done", 1);
    check("t4b_writes", wr_q.size(),     32'd1);
    w = wr_q[0];
    check("t4b_wdata",  w.data,          32'h34);
    check("t4b_bready", 32'(saw_bready), 32'd1);

    // Both channels stalled equally, so they complete in the same cycle.
    wr_q.delete(); saw_bready = 1'b0; aw_dly = 2; w_dly = 2;
    push_byte(8'h35);
    wait_done("t4c_done", 1);
    check("t4c_writes", wr_q.size(),     32'd1);
    w = wr_q[0];
    check("t4c_wdata",  w.data,          32'h35);
    check("t4c_bready", 32'(saw_bready), 32'd1);
    aw_dly = 0; w_dly = 0;

    // SLVERR on the write response: sticky error, byte popped, no retry.
    wr_q.delete(); n_reads = 0; bresp_cfg = 2'b10;
    push_byte(8'h55);
    wait_done("t5_done", 1);
    check("t5_err",   32'(o_err),   32'd1);
    check("t5_level", 32'(o_level), 32'd0);
    repeat (10) tick();
    check("t5_no_retry", wr_q.size(), 32'd1);
    check("t5_reads",    n_reads,     32'd1);
    w = wr_q[0];
    check("t5_wdata",    w.data,      32'h55);
    bresp_cfg = 2'b00;
    push_byte(8'h66);
    wait_done("t5b_done", 2);
    check("t5_err_sticky", 32'(o_err), 32'd1);

    // Reset while a STATUS read is in its data phase with bytes queued.
    wr_q.delete(); n_reads = 0; zeros_left = 1000;
    push_byte(8'hA0);
    push_byte(8'hA1);
    push_byte(8'hA2);
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (m_axi_rready) begin seen = 1'b1; break; end
      tick();
    end
    check("t6_in_rd_data", 32'(seen),    32'd1);
    check("t6_level_pre",  32'(o_level), 32'd3);
    i_rst = 1'b1;
    repeat (2) tick();
    check_idle_outputs("t6_rst");
    i_rst = 1'b0; zeros_left = 0;
    snap_r = n_reads; snap_w = wr_q.size();
    tick();
    check("t6_ready_after", 32'(o_ready), 32'd1);
    any_ar = 1'b0;
    repeat (20) begin
      if (m_axi_arvalid || m_axi_awvalid || m_axi_wvalid) any_ar = 1'b1;
      tick();
    end
    check("t6_no_axi",    32'(any_ar),  32'd0);
    check("t6_reads",     n_reads,      32'(snap_r));
    check("t6_writes",    wr_q.size(),  32'(snap_w));
    check("t6_level",     32'(o_level), 32'd0);
    check("t6_busy",      32'(o_busy),  32'd0);

    check("single_outstanding", n_overlap, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
